// File: rtl/m_sync_pkg.sv
// Shared definitions for the synchronizer / glitch-filter blocks: filter state
// encoding, glitch counter width and synchronizer depth limits.
package m_sync_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } filt_state_t;

  localparam int unsigned GLITCH_CNT_W    = 8;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
    return (v == '1) ? v : v + GLITCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/m_ffsync_arst.sv
// Standard first-stage synchronizer cell: single flop with async active-low reset.
module m_ffsync_arst (
  input  logic CK,
  input  logic RN,
  input  logic D,
  output logic Q
);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) Q <= 1'b0;
    else     Q <= D;
  end

endmodule

// File: rtl/m_sync_chain.sv
// N-stage synchronizer: sync-FF cell for stage 1, plain async-reset flops after.
// Only the final stage output is exposed.
module m_sync_chain
  import m_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CK,
  input  logic RN,
  input  logic D,
  output logic s
);

  logic                   s1;
  logic [SYNC_STAGES-2:0] tail;

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("m_sync_chain: SYNC_STAGES out of range");
  end

  m_ffsync_arst u_stage1 (
    .CK (CK),
    .RN (RN),
    .D  (D),
    .Q  (s1)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      tail <= '0;
    end else begin
      tail[0] <= s1;
      for (int unsigned i = 1; i < SYNC_STAGES - 1; i++) tail[i] <= tail[i-1];
    end
  end

  assign s = tail[SYNC_STAGES-2];

endmodule

// File: rtl/m_sync_filt_edge.sv
// Synchronizer + consecutive-sample glitch filter with registered level and edge pulses.
// Optional saturating glitch counter enabled by `define M_SYNC_FILT_GLITCH_CNT_EN.
module m_sync_filt_edge
  import m_sync_pkg::*;
#(
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned FILT_CYCLES = 4,
  localparam int unsigned CNT_W       = $clog2(FILT_CYCLES + 1)
) (
  input  logic CK,
  input  logic RN,
  input  logic D,
  input  logic EN,
  output logic Q,
  output logic RISE,
  output logic FALL
`ifdef M_SYNC_FILT_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] GLITCH_CNT
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
    $error("m_sync_filt_edge: FILT_CYCLES out of range");
  end

  logic             s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             q_nxt;
  filt_state_t      state;

  m_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_chain (
    .CK (CK),
    .RN (RN),
    .D  (D),
    .s  (s)
  );

  // State is implied by the counter: any nonzero count means a qualification is in flight.
  always_comb begin
    state   = (cnt == '0) ? ST_STABLE : ST_PENDING;
    q_nxt   = Q;
    cnt_nxt = '0;
    if (EN) begin
      case (state)
        ST_STABLE: begin
          if (s != Q) begin
            if (FILT_CYCLES == 1) q_nxt   = s;
            else                  cnt_nxt = CNT_ONE;
          end
        end
        ST_PENDING: begin
          if (s != Q) begin
            if (cnt == CNT_LAST) q_nxt   = s;
            else                 cnt_nxt = cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      Q    <= 1'b0;
      cnt  <= '0;
      RISE <= 1'b0;
      FALL <= 1'b0;
    end else begin
      Q    <= q_nxt;
      cnt  <= cnt_nxt;
      RISE <= q_nxt & ~Q;
      FALL <= ~q_nxt & Q;
    end
  end

`ifdef M_SYNC_FILT_GLITCH_CNT_EN
  logic glitch_abort;

  assign glitch_abort = EN && (state == ST_PENDING) && (s == Q);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN)               GLITCH_CNT <= '0;
    else if (glitch_abort) GLITCH_CNT <= sat_inc(GLITCH_CNT);
  end
`endif

endmodule

// File: tb/tb_m_sync_filt_edge.sv
// Table-driven scoreboard bench for m_sync_filt_edge (defaults, and FILT_CYCLES=1/SYNC_STAGES=3).
module tb_m_sync_filt_edge;

  logic CK = 1'b0;
  logic RN;
  logic d1, en1, q1, r1, f1;
  logic d2, en2, q2, r2, f2;
`ifdef M_SYNC_FILT_GLITCH_CNT_EN
  logic [7:0] g1, g2;
`endif

  always #5 CK = ~CK;

  m_sync_filt_edge #(.SYNC_STAGES(2), .FILT_CYCLES(4)) u_dut1 (
    .CK   (CK),
    .RN   (RN),
    .D    (d1),
    .EN   (en1),
    .Q    (q1),
    .RISE (r1),
    .FALL (f1)
`ifdef M_SYNC_FILT_GLITCH_CNT_EN
    ,
    .GLITCH_CNT (g1)
`endif
  );

  m_sync_filt_edge #(.SYNC_STAGES(3), .FILT_CYCLES(1)) u_dut2 (
    .CK   (CK),
    .RN   (RN),
    .D    (d2),
    .EN   (en2),
    .Q    (q2),
    .RISE (r2),
    .FALL (f2)
`ifdef M_SYNC_FILT_GLITCH_CNT_EN
    ,
    .GLITCH_CNT (g2)
`endif
  );

  typedef struct {
    bit d;
    bit en;
    bit q;
    bit r;
    bit f;
    int g;
  } vec_t;

  typedef struct {
    bit which;
    bit q;
    bit r;
    bit f;
    int g;
    int idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  function automatic void add(int n, bit d, bit en, bit q, bit r, bit f, int g = -1);
    for (int i = 0; i < n; i++)
      tbl.push_back('{d: d, en: en, q: q, r: r, f: f, g: (i == n - 1) ? g : -1});
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", vec_no, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (!e.which) begin
      chk("q1", e.idx, q1, e.q);
      chk("rise1", e.idx, r1, e.r);
      chk("fall1", e.idx, f1, e.f);
`ifdef M_SYNC_FILT_GLITCH_CNT_EN
      if (e.g >= 0) chk("glitch_cnt1", e.idx, g1, e.g);
`endif
    end else begin
      chk("q2", e.idx, q2, e.q);
      chk("rise2", e.idx, r2, e.r);
      chk("fall2", e.idx, f2, e.f);
    end
  endtask

  task automatic drive(input vec_t v, input bit which);
    if (!which) begin d1 = v.d; en1 = v.en; end
    else        begin d2 = v.d; en2 = v.en; end
    sb.push_back('{which: which, q: v.q, r: v.r, f: v.f, g: v.g, idx: vec_no});
    vec_no++;
    @(posedge CK);
    #1;
    compare();
  endtask

  task automatic run_tbl(input bit which);
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i], which);
    tbl.delete();
  endtask

  task automatic seg_rise();
    add(5, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    add(2, 1, 1, 1, 0, 0);
  endtask

  task automatic seg_fall();
    add(5, 0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 1);
    add(2, 0, 1, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RN = 1'b0;
    d1 = 1'b0; en1 = 1'b1;
    d2 = 1'b0; en2 = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    chk("rst_q1", -1, q1, 0);
    chk("rst_rise1", -1, r1, 0);
    chk("rst_fall1", -1, f1, 0);
    chk("rst_q2", -1, q2, 0);
`ifdef M_SYNC_FILT_GLITCH_CNT_EN
    chk("rst_glitch1", -1, g1, 0);
`endif
    #2 RN = 1'b1;

    // Main table on the default instance.
    add(3, 0, 1, 0, 0, 0);
    seg_rise();
    seg_fall();
    add(2, 1, 1, 0, 0, 0);                   // 2-sample glitch
    add(8, 0, 1, 0, 0, 0, 1);
    add(3, 1, 1, 0, 0, 0);                   // FILT_CYCLES-1 glitch
    add(8, 0, 1, 0, 0, 0, 2);
    add(4, 1, 1, 0, 0, 0);                   // minimum accepted pulse
    add(1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0);
    add(3, 0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 1);
    add(2, 0, 1, 0, 0, 0, 2);
    add(20, 1, 0, 0, 0, 0);                  // EN low while D high
    add(3, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    add(2, 1, 1, 1, 0, 0);
    seg_fall();
    add(5, 1, 1, 0, 0, 0);                   // EN drop on completing edge
    add(1, 1, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    add(2, 1, 1, 1, 0, 0);
    seg_fall();
    add(1, 0, 1, 0, 0, 0, 2);
    run_tbl(0);

    // D toggling every 3 cycles: every high run is rejected.
    for (int i = 0; i < 40; i++)
      drive('{d: ((i / 3) % 2 == 0), en: 1'b1, q: 1'b0, r: 1'b0, f: 1'b0, g: -1}, 0);
    add(6, 0, 1, 0, 0, 0, 9);
    run_tbl(0);

    // Extended run to saturate the glitch counter.
    for (int i = 0; i < 600; i++)
      drive('{d: (i % 2 == 0), en: 1'b1, q: 1'b0, r: 1'b0, f: 1'b0, g: -1}, 0);
    add(4, 0, 1, 0, 0, 0, 255);
    run_tbl(0);

    // Reset in the middle of a falling qualification.
    seg_rise();
    add(4, 0, 1, 1, 0, 0);
    run_tbl(0);
    #2 RN = 1'b0;
    #1;
    chk("arst_q1", vec_no, q1, 0);
    chk("arst_rise1", vec_no, r1, 0);
    chk("arst_fall1", vec_no, f1, 0);
    chk("arst_cnt1", vec_no, u_dut1.cnt, 0);
`ifdef M_SYNC_FILT_GLITCH_CNT_EN
    chk("arst_glitch1", vec_no, g1, 0);
`endif
    @(posedge CK);
    #3 RN = 1'b1;
    add(10, 0, 1, 0, 0, 0, 0);
    run_tbl(0);

    // FILT_CYCLES=1, SYNC_STAGES=3 instance.
    add(3, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0);
    add(2, 1, 1, 1, 0, 0);
    add(1, 0, 1, 1, 0, 0);
    add(2, 1, 1, 1, 0, 0);
    add(1, 1, 1, 0, 0, 1);
    add(1, 1, 1, 1, 1, 0);
    add(2, 1, 1, 1, 0, 0);
    run_tbl(1);

    chk("scoreboard_drained", vec_no, sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
